// File: rtl/tour_sequencer.sv
// Replays solved knight-tour moves as Y-then-X single-axis motion commands.
// Build option MOVE_CHECK_EN: reject non-one-hot moves via the sticky err flag.
module tour_sequencer #(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       x_start,
  input  logic [2:0]       y_start,
  output logic             tl_go,
  output logic [2:0]       tl_x,
  output logic [2:0]       tl_y,
  input  logic             tl_done,
  output logic [IDX_W-1:0] tl_indx,
  input  logic [7:0]       tl_move,
  output logic             cmd_vld,
  input  logic             cmd_rdy,
  output logic [1:0]       cmd_dir,
  output logic [1:0]       cmd_sq,
  input  logic             cmd_done,
  output logic             busy,
  output logic             tour_cmplt,
  output logic             err
);

  typedef enum logic [3:0] {
    IDLE, SOLVE, FETCH, YREQ, YWAIT, XREQ, XWAIT, NEXT, FIN
  } state_t;

  localparam logic [1:0] DIR_PY = 2'd0;
  localparam logic [1:0] DIR_NX = 2'd1;
  localparam logic [1:0] DIR_NY = 2'd2;
  localparam logic [1:0] DIR_PX = 2'd3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

  state_t     state, state_nxt;
  logic [7:0] mv_r;
  logic [2:0] mv_sel;
  logic [1:0] y_dir, y_sq, x_dir, x_sq;
  logic       bad_move;
  logic       accept;

  assign accept = (state == IDLE) && start;

`ifdef MOVE_CHECK_EN
  assign bad_move = (tl_move == 8'd0) || ((tl_move & (tl_move - 8'd1)) != 8'd0);
`else
  assign bad_move = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = SOLVE;
      SOLVE:   if (tl_done)  state_nxt = FETCH;
      FETCH:   state_nxt = bad_move ? IDLE : YREQ;
      YREQ:    if (cmd_rdy)  state_nxt = YWAIT;
      YWAIT:   if (cmd_done) state_nxt = XREQ;
      XREQ:    if (cmd_rdy)  state_nxt = XWAIT;
      XWAIT:   if (cmd_done) state_nxt = NEXT;
      NEXT:    state_nxt = (tl_indx == LAST_IDX) ? FIN : FETCH;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tl_go   <= 1'b0;
      tl_x    <= 3'd0;
      tl_y    <= 3'd0;
      tl_indx <= '0;
      mv_r    <= 8'd0;
    end else begin
      tl_go <= accept;
      if (accept) begin
        tl_x    <= x_start;
        tl_y    <= y_start;
        tl_indx <= '0;
      end
      if (state == FETCH) mv_r <= tl_move;
      if (state == NEXT && tl_indx != LAST_IDX) tl_indx <= tl_indx + 1'b1;
    end
  end

  // Lowest set bit wins; an all-zero move falls through to bit 0.
  always_comb begin
    mv_sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mv_r[i]) mv_sel = 3'(i);
    end
  end

  always_comb begin
    y_dir = DIR_PY;
    y_sq  = 2'd2;
    x_dir = DIR_PX;
    x_sq  = 2'd1;
    case (mv_sel)
      3'd0: begin y_dir = DIR_PY; y_sq = 2'd2; x_dir = DIR_PX; x_sq = 2'd1; end
      3'd1: begin y_dir = DIR_PY; y_sq = 2'd2; x_dir = DIR_NX; x_sq = 2'd1; end
      3'd2: begin y_dir = DIR_PY; y_sq = 2'd1; x_dir = DIR_NX; x_sq = 2'd2; end
      3'd3: begin y_dir = DIR_NY; y_sq = 2'd1; x_dir = DIR_NX; x_sq = 2'd2; end
      3'd4: begin y_dir = DIR_NY; y_sq = 2'd2; x_dir = DIR_NX; x_sq = 2'd1; end
      3'd5: begin y_dir = DIR_NY; y_sq = 2'd2; x_dir = DIR_PX; x_sq = 2'd1; end
      3'd6: begin y_dir = DIR_NY; y_sq = 2'd1; x_dir = DIR_PX; x_sq = 2'd2; end
      default: begin y_dir = DIR_PY; y_sq = 2'd1; x_dir = DIR_PX; x_sq = 2'd2; end
    endcase
  end

  always_comb begin
    cmd_vld = 1'b0;
    cmd_dir = 2'd0;
    cmd_sq  = 2'd0;
    if (state == YREQ) begin
      cmd_vld = 1'b1;
      cmd_dir = y_dir;
      cmd_sq  = y_sq;
    end else if (state == XREQ) begin
      cmd_vld = 1'b1;
      cmd_dir = x_dir;
      cmd_sq  = x_sq;
    end
  end

  assign busy       = (state != IDLE);
  assign tour_cmplt = (state == FIN);

`ifdef MOVE_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                           err <= 1'b0;
    else if (accept)                   err <= 1'b0;
    else if (state == FETCH && bad_move) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tour_sequencer.sv
// Scoreboard bench for tour_sequencer: solver and motion-path models drive random
// tours; a monitor compares each accepted command against the knight-move reference.
module tb_tour_sequencer;
  localparam int NUM_MOVES = 24;
  localparam int IDX_W     = 5;
  localparam int LAST      = NUM_MOVES - 1;
  localparam int BOUND     = 4000;

  typedef struct packed { logic [1:0] dir; logic [1:0] sq; } leg_t;

  logic clk = 1'b0;
  logic rst, start, tl_done, cmd_rdy, cmd_done;
  logic [2:0] x_start, y_start, tl_x, tl_y;
  logic tl_go, cmd_vld, busy, tour_cmplt, err;
  logic [IDX_W-1:0] tl_indx;
  logic [7:0] tl_move;
  logic [1:0] cmd_dir, cmd_sq;

  int compared = 0, mismatched = 0;
  int xfer_cnt = 0, cmplt_cnt = 0, go_cnt = 0, stall_run = 0, max_stall = 0;
  int rdy_mode = 0, dly_min = 3, dly_max = 3;
  logic prev_stall = 1'b0;
  leg_t prev_leg;
  logic [7:0] mv_tbl [NUM_MOVES];
  leg_t exp_q [$];
  int dx_tbl [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int dy_tbl [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  always #5 clk = ~clk;

  tour_sequencer #(.NUM_MOVES(NUM_MOVES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .x_start(x_start), .y_start(y_start),
    .tl_go(tl_go), .tl_x(tl_x), .tl_y(tl_y), .tl_done(tl_done), .tl_indx(tl_indx),
    .tl_move(tl_move), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_dir(cmd_dir),
    .cmd_sq(cmd_sq), .cmd_done(cmd_done), .busy(busy), .tour_cmplt(tour_cmplt), .err(err)
  );

  // Solver model answers the presented index combinationally.
  assign tl_move = (int'(tl_indx) < NUM_MOVES) ? mv_tbl[int'(tl_indx)] : 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: first set bit picks the (dx,dy) jump; Y leg then X leg.
  function automatic void pushMove(input logic [7:0] mv);
    int k;
    int dx;
    int dy;
    leg_t leg;
    k = -1;
    for (int i = 0; i < 8; i++) if (mv[i] && k < 0) k = i;
    if (k < 0) k = 0;
    dx = dx_tbl[k];
    dy = dy_tbl[k];
    leg.dir = (dy > 0) ? 2'd0 : 2'd2;
    leg.sq  = 2'((dy > 0) ? dy : -dy);
    exp_q.push_back(leg);
    leg.dir = (dx > 0) ? 2'd3 : 2'd1;
    leg.sq  = 2'((dx > 0) ? dx : -dx);
    exp_q.push_back(leg);
  endfunction

  function automatic logic [7:0] randMove();
    logic [7:0] m;
    m = 8'h01 << $urandom_range(7, 0);
`ifndef MOVE_CHECK_EN
    if ($urandom_range(3, 0) == 0) m = 8'($urandom);
`endif
    return m;
  endfunction

  // Motion-path model: ready policy plus a delayed done pulse per transfer.
  initial begin
    int cnt;
    int stall;
    logic was_xfer, vld_seen;
    cnt = 0;
    stall = 0;
    cmd_rdy = 1'b0;
    cmd_done = 1'b0;
    forever begin
      @(negedge clk);
      was_xfer = cmd_vld && cmd_rdy;
      vld_seen = cmd_vld;
      @(posedge clk);
      #1;
      if (was_xfer) cnt = $urandom_range(dly_max, dly_min);
      cmd_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) cmd_done = 1'b1;
      end
      stall = (vld_seen && !was_xfer) ? stall + 1 : 0;
      case (rdy_mode)
        0:       cmd_rdy = 1'b1;
        1:       cmd_rdy = 1'($urandom_range(1, 0));
        default: cmd_rdy = (stall >= 5);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks handshake stability.
  always @(negedge clk) begin
    leg_t want;
    if (rst) begin
      prev_stall = 1'b0;
      stall_run = 0;
    end else begin
      if (prev_stall) begin
        checkOutput("hold_vld", 32'(cmd_vld), 32'd1);
        checkOutput("hold_fields", 32'({cmd_dir, cmd_sq}), 32'(prev_leg));
      end
      if (tl_go) go_cnt++;
      if (tour_cmplt) cmplt_cnt++;
      if (cmd_vld && cmd_rdy) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL cmd_leg: got dir=%0d sq=%0d, expected no command", cmd_dir, cmd_sq);
        end else begin
          want = exp_q.pop_front();
          checkOutput("cmd_leg", 32'({cmd_dir, cmd_sq}), 32'(want));
        end
        stall_run = 0;
        prev_stall = 1'b0;
      end else if (cmd_vld) begin
        stall_run++;
        if (stall_run > max_stall) max_stall = stall_run;
        prev_stall = 1'b1;
        prev_leg = {cmd_dir, cmd_sq};
      end else begin
        stall_run = 0;
        prev_stall = 1'b0;
      end
    end
  end

  task automatic fillMoves(input int first_mv, input bit all80, input int upto);
    for (int i = 0; i < NUM_MOVES; i++) mv_tbl[i] = all80 ? 8'h80 : randMove();
    if (first_mv >= 0) mv_tbl[0] = 8'(first_mv);
    for (int i = 0; i < upto; i++) pushMove(mv_tbl[i]);
  endtask

  task automatic applyStimulus(input logic [2:0] x, input logic [2:0] y, input int solve_delay);
    @(posedge clk);
    #1 start = 1'b1; x_start = x; y_start = y;
    @(posedge clk);
    #1 start = 1'b0; x_start = ~x; y_start = ~y;
    @(negedge clk);
    checkOutput("tl_go_pulse", 32'(tl_go), 32'd1);
    checkOutput("tl_x", 32'(tl_x), 32'(x));
    checkOutput("tl_y", 32'(tl_y), 32'(y));
    checkOutput("start_indx", 32'(tl_indx), 32'd0);
    checkOutput("busy_solve", 32'(busy), 32'd1);
    checkOutput("err_clear", 32'(err), 32'd0);
    @(negedge clk);
    checkOutput("tl_go_single", 32'(tl_go), 32'd0);
    repeat (solve_delay) @(posedge clk);
    #1 tl_done = 1'b1;
    @(posedge clk);
    #1 tl_done = 1'b0;
    @(negedge clk);
    checkOutput("fetch_no_vld", 32'(cmd_vld), 32'd0);
    @(negedge clk);
    checkOutput("first_vld_latency", 32'(cmd_vld), 32'd1);
    checkOutput("first_indx", 32'(tl_indx), 32'd0);
  endtask

  task automatic waitTour();
    int n;
    n = 0;
    while (!tour_cmplt && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!tour_cmplt) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL tour_timeout: got no tour_cmplt, expected one within %0d cycles", BOUND);
    end else begin
      checkOutput("final_indx", 32'(tl_indx), LAST);
      checkOutput("busy_in_fin", 32'(busy), 32'd1);
      @(negedge clk);
      checkOutput("busy_after_fin", 32'(busy), 32'd0);
      checkOutput("cmplt_single", 32'(tour_cmplt), 32'd0);
    end
  endtask

  task automatic runTour(input logic [2:0] x, input logic [2:0] y, input int solve_delay,
                         input int first_mv, input bit all80, input int rdy,
                         input int dmin, input int dmax, input bit poke);
    int xfer0, cmplt0, go0;
    rdy_mode = rdy;
    dly_min = dmin;
    dly_max = dmax;
    fillMoves(first_mv, all80, NUM_MOVES);
    xfer0 = xfer_cnt;
    cmplt0 = cmplt_cnt;
    go0 = go_cnt;
    max_stall = 0;
    applyStimulus(x, y, solve_delay);
    if (poke) begin
      repeat (4) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    waitTour();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("xfer_count", xfer_cnt - xfer0, 2 * NUM_MOVES);
    checkOutput("cmplt_count", cmplt_cnt - cmplt0, 32'd1);
    checkOutput("go_count", go_cnt - go0, 32'd1);
    checkOutput("tl_x_held", 32'(tl_x), 32'(x));
    checkOutput("tl_y_held", 32'(tl_y), 32'(y));
    checkOutput("indx_held", 32'(tl_indx), LAST);
    if (rdy == 2) checkOutput("stall_run", max_stall, 32'd5);
  endtask

  task automatic runAbort();
    int xfer0, n;
    rdy_mode = 0;
    dly_min = 6;
    dly_max = 6;
    fillMoves(-1, 1'b1, NUM_MOVES);
    xfer0 = xfer_cnt;
    applyStimulus(3'd3, 3'd5, 4);
    n = 0;
    while ((xfer_cnt - xfer0) < 16 && n < BOUND) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("abort_xfers", xfer_cnt - xfer0, 32'd16);
    checkOutput("abort_indx", 32'(tl_indx), 32'd7);
    checkOutput("xwait_no_vld", 32'(cmd_vld), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_vld", 32'(cmd_vld), 32'd0);
    checkOutput("abort_indx_zero", 32'(tl_indx), 32'd0);
    checkOutput("abort_tl_x", 32'(tl_x), 32'd0);
    checkOutput("abort_cmplt", 32'(tour_cmplt), 32'd0);
    repeat (8) @(negedge clk);
    checkOutput("late_done_busy", 32'(busy), 32'd0);
    checkOutput("late_done_vld", 32'(cmd_vld), 32'd0);
  endtask

`ifdef MOVE_CHECK_EN
  task automatic runMoveCheck();
    int xfer0, cmplt0, n;
    rdy_mode = 0;
    dly_min = 1;
    dly_max = 2;
    fillMoves(-1, 1'b0, 0);
    mv_tbl[3] = 8'h05;
    for (int i = 0; i < 3; i++) pushMove(mv_tbl[i]);
    xfer0 = xfer_cnt;
    cmplt0 = cmplt_cnt;
    applyStimulus(3'd1, 3'd6, 3);
    n = 0;
    while (busy && n < BOUND) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("err_set", 32'(err), 32'd1);
    checkOutput("err_busy", 32'(busy), 32'd0);
    checkOutput("err_xfers", xfer_cnt - xfer0, 32'd6);
    checkOutput("err_no_cmplt", cmplt_cnt - cmplt0, 32'd0);
    checkOutput("err_queue", 32'(exp_q.size()), 32'd0);
    checkOutput("err_indx", 32'(tl_indx), 32'd3);
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0;
    tl_done = 1'b0;
    x_start = 3'd0;
    y_start = 3'd0;
    for (int i = 0; i < NUM_MOVES; i++) mv_tbl[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tl_go", 32'(tl_go), 32'd0);
    checkOutput("rst_indx", 32'(tl_indx), 32'd0);
    checkOutput("rst_vld", 32'(cmd_vld), 32'd0);
    checkOutput("rst_dir", 32'(cmd_dir), 32'd0);
    checkOutput("rst_sq", 32'(cmd_sq), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cmplt", 32'(tour_cmplt), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_xy", 32'({tl_x, tl_y}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    runTour(3'd2, 3'd2, 10, 8'h01, 1'b0, 0, 3, 3, 1'b0);
    runTour(3'd5, 3'd0, 2, 8'h08, 1'b0, 0, 3, 3, 1'b1);
    runTour(3'd0, 3'd7, 1, -1, 1'b1, 2, 1, 2, 1'b0);
    runTour(3'd4, 3'd3, 5, -1, 1'b0, 1, 1, 4, 1'b0);
`ifndef MOVE_CHECK_EN
    runTour(3'd6, 3'd1, 3, 8'h00, 1'b0, 1, 1, 3, 1'b0);
    runTour(3'd1, 3'd4, 2, 8'h06, 1'b0, 1, 1, 3, 1'b0);
`endif
    runAbort();
    runTour(3'd7, 3'd0, 4, -1, 1'b0, 1, 1, 4, 1'b1);
`ifdef MOVE_CHECK_EN
    runMoveCheck();
    runTour(3'd2, 3'd5, 2, -1, 1'b0, 1, 1, 3, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
